// File: rtl/ctr_buffer_pkg.sv
// Shared types and helpers for the control-transfer-record buffer.
package ctr_buffer_pkg;

    localparam int unsigned CtrTypeW = 4;
    localparam int unsigned CtrMaskW = 16;

    // Control transfer type encodings; 0 means "no transfer".
    typedef enum logic [CtrTypeW-1:0] {
        CTR_NONE    = 4'd0,
        CTR_EXC     = 4'd1,
        CTR_INT     = 4'd2,
        CTR_TRET    = 4'd3,
        CTR_NTBR    = 4'd4,
        CTR_TKBR    = 4'd5,
        CTR_RSV6    = 4'd6,
        CTR_RSV7    = 4'd7,
        CTR_INDCALL = 4'd8,
        CTR_DIRCALL = 4'd9,
        CTR_INDJMP  = 4'd10,
        CTR_DIRJMP  = 4'd11,
        CTR_CORSWAP = 4'd12,
        CTR_RET     = 4'd13,
        CTR_INDLJMP = 4'd14,
        CTR_DIRLJMP = 4'd15
    } ctr_type_t;

    // A transfer type is recordable when it is a real transfer and not inhibited.
    function automatic logic ctr_type_allowed(input logic [CtrTypeW-1:0] t,
                                              input logic [CtrMaskW-1:0] mask);
        return (t != CTR_NONE) && !mask[t];
    endfunction

endpackage

// File: rtl/ctr_commit_compactor.sv
// Turns the per-port accept vector into dense write offsets (prefix popcount)
// and the total number of accepted ports. Purely combinational.
module ctr_commit_compactor #(
    parameter int unsigned NrCommitPorts = 2,
    localparam int unsigned CntW = $clog2(NrCommitPorts + 1)
) (
    input  logic [NrCommitPorts-1:0]           accept,
    output logic [NrCommitPorts-1:0][CntW-1:0] offset,
    output logic [CntW-1:0]                    num
);

    logic [CntW-1:0] acc;

    // Running count of accepted ports below each port gives that port's slot offset.
    always_comb begin
        acc    = '0;
        offset = '0;
        for (int p = 0; p < NrCommitPorts; p++) begin
            offset[p] = acc;
            acc       = acc + CntW'(accept[p]);
        end
        num = acc;
    end

endmodule

// File: rtl/ctr_buffer.sv
// Control Transfer Records storage engine: filters retired control transfers,
// stores them in a circular buffer with elapsed-cycle counts, and exposes the
// buffer through a logical-index read port (index 0 = most recent record).
module ctr_buffer
    import ctr_buffer_pkg::*;
#(
    parameter int unsigned NrCommitPorts = 2,
    parameter int unsigned VLEN          = 64,
    parameter int unsigned Depth         = 16,
    parameter int unsigned CcWidth       = 16,
    localparam int unsigned IdxW         = $clog2(Depth)
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [NrCommitPorts-1:0]                valid_i,
    input  logic [NrCommitPorts-1:0][VLEN-1:0]      source_pc_i,
    input  logic [NrCommitPorts-1:0][VLEN-1:0]      target_pc_i,
    input  logic [NrCommitPorts-1:0][CtrTypeW-1:0]  type_i,
    input  logic                                    en_i,
    input  logic [CtrMaskW-1:0]                     type_mask_i,
    input  logic                                    freeze_i,
    input  logic                                    clear_i,
    input  logic [IdxW-1:0]                         rd_idx_i,
    output logic                                    rd_valid_o,
    output logic [VLEN-1:0]                         rd_source_o,
    output logic [VLEN-1:0]                         rd_target_o,
    output logic [CtrTypeW-1:0]                     rd_type_o,
    output logic [CcWidth-1:0]                      rd_cc_o,
    output logic [IdxW:0]                           count_o,
    output logic                                    overflow_o
);

    localparam int unsigned CntW = $clog2(NrCommitPorts + 1);
    localparam logic [IdxW+1:0] DepthW = (IdxW + 2)'(Depth);

    typedef struct packed {
        logic [VLEN-1:0]     source;
        logic [VLEN-1:0]     target;
        logic [CtrTypeW-1:0] ttype;
        logic [CcWidth-1:0]  cc;
    } ctr_entry_t;

    ctr_entry_t mem [Depth];

    logic [IdxW-1:0]    wptr;
    logic [IdxW:0]      count;
    logic [CcWidth-1:0] cc;
    logic               overflow;

    logic [NrCommitPorts-1:0]           accept;
    logic [NrCommitPorts-1:0][CntW-1:0] offset;
    logic [CntW-1:0]                    num;
    logic [NrCommitPorts-1:0][IdxW-1:0] slot;
    logic [IdxW+1:0]                    total;
    logic                               ovf_now;
    logic [IdxW-1:0]                    rd_slot;
    ctr_entry_t                         rd_entry;

    // Per-port filter: enabled, not frozen/cleared, real and uninhibited type.
    always_comb begin
        accept = '0;
        for (int p = 0; p < NrCommitPorts; p++) begin
            accept[p] = valid_i[p] & en_i & ~freeze_i & ~clear_i
                        & ctr_type_allowed(type_i[p], type_mask_i);
        end
    end

    ctr_commit_compactor #(
        .NrCommitPorts(NrCommitPorts)
    ) u_compactor (
        .accept(accept),
        .offset(offset),
        .num   (num)
    );

    // Physical write slots follow wptr in port order and wrap modulo Depth.
    always_comb begin
        slot = '0;
        for (int p = 0; p < NrCommitPorts; p++) begin
            slot[p] = wptr + IdxW'(offset[p]);
        end
        total   = (IdxW + 2)'(count) + (IdxW + 2)'(num);
        ovf_now = total > DepthW;
    end

    // Pointer, occupancy, cycle counter and sticky overflow; clear wins over everything.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr     <= '0;
            count    <= '0;
            cc       <= '0;
            overflow <= 1'b0;
        end else if (clear_i) begin
            wptr     <= '0;
            count    <= '0;
            cc       <= '0;
            overflow <= 1'b0;
        end else begin
            wptr  <= wptr + IdxW'(num);
            count <= ovf_now ? DepthW[IdxW:0] : total[IdxW:0];
            if (ovf_now) begin
                overflow <= 1'b1;
            end
            if (num != '0) begin
                cc <= '0;
            end else if (en_i && !freeze_i && !(&cc)) begin
                cc <= cc + CcWidth'(1);
            end
        end
    end

    // Record storage; only the first record of a cycle carries the elapsed count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NrCommitPorts; p++) begin
                if (accept[p]) begin
                    mem[slot[p]] <= '{source: source_pc_i[p],
                                      target: target_pc_i[p],
                                      ttype:  type_i[p],
                                      cc:     (offset[p] == '0) ? cc : '0};
                end
            end
        end
    end

    // Logical index 0 maps to the slot just behind wptr; invalid reads return zeros.
    always_comb begin
        rd_slot     = wptr - IdxW'(1) - rd_idx_i;
        rd_entry    = mem[rd_slot];
        rd_valid_o  = {1'b0, rd_idx_i} < count;
        rd_source_o = '0;
        rd_target_o = '0;
        rd_type_o   = '0;
        rd_cc_o     = '0;
        if (rd_valid_o) begin
            rd_source_o = rd_entry.source;
            rd_target_o = rd_entry.target;
            rd_type_o   = rd_entry.ttype;
            rd_cc_o     = rd_entry.cc;
        end
    end

    assign count_o    = count;
    assign overflow_o = overflow;

endmodule

// File: tb/tb_ctr_buffer.sv
// Directed bench for ctr_buffer with Depth=16, two commit ports, VLEN=32.
module tb_ctr_buffer;

    localparam int unsigned NP   = 2;
    localparam int unsigned VL   = 32;
    localparam int unsigned DEP  = 16;
    localparam int unsigned CCW  = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NP-1:0]           valid;
    logic [NP-1:0][VL-1:0]   source_pc;
    logic [NP-1:0][VL-1:0]   target_pc;
    logic [NP-1:0][3:0]      ttype;
    logic                    en;
    logic [15:0]             type_mask;
    logic                    freeze;
    logic                    clear;
    logic [3:0]              rd_idx;
    logic                    rd_valid;
    logic [VL-1:0]           rd_source;
    logic [VL-1:0]           rd_target;
    logic [3:0]              rd_type;
    logic [CCW-1:0]          rd_cc;
    logic [4:0]              count;
    logic                    overflow;

    int errors = 0;
    int checks = 0;

    ctr_buffer #(
        .NrCommitPorts(NP),
        .VLEN         (VL),
        .Depth        (DEP),
        .CcWidth      (CCW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .valid_i    (valid),
        .source_pc_i(source_pc),
        .target_pc_i(target_pc),
        .type_i     (ttype),
        .en_i       (en),
        .type_mask_i(type_mask),
        .freeze_i   (freeze),
        .clear_i    (clear),
        .rd_idx_i   (rd_idx),
        .rd_valid_o (rd_valid),
        .rd_source_o(rd_source),
        .rd_target_o(rd_target),
        .rd_type_o  (rd_type),
        .rd_cc_o    (rd_cc),
        .count_o    (count),
        .overflow_o (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic read_chk(input string tag, input logic [3:0] idx, input logic vld,
                            input logic [31:0] src, input logic [31:0] tgt,
                            input logic [3:0] ty, input logic [15:0] c);
        rd_idx = idx;
        #1;
        chk({tag, "_valid"}, rd_valid, vld);
        chk({tag, "_src"}, rd_source, src);
        chk({tag, "_tgt"}, rd_target, tgt);
        chk({tag, "_type"}, rd_type, ty);
        chk({tag, "_cc"}, rd_cc, c);
    endtask

    task automatic idle();
        valid = '0;
    endtask

    task automatic put0(input logic [31:0] src, input logic [31:0] tgt, input logic [3:0] ty);
        valid        = 2'b01;
        source_pc[0] = src;
        target_pc[0] = tgt;
        ttype[0]     = ty;
    endtask

    initial begin
        rst       = 1'b1;
        valid     = '0;
        source_pc = '0;
        target_pc = '0;
        ttype     = '0;
        en        = 1'b0;
        type_mask = '0;
        freeze    = 1'b0;
        clear     = 1'b0;
        rd_idx    = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_count", count, 5'd0);
        chk("rst_ovf", overflow, 1'b0);
        read_chk("rst_idx0", 4'd0, 1'b0, 32'h0, 32'h0, 4'd0, 16'd0);

        // Single record after 5 idle enabled cycles
        en = 1'b1;
        repeat (5) tick();
        put0(32'h100, 32'h200, 4'd1);
        tick();
        idle();
        chk("single_count", count, 5'd1);
        read_chk("single_idx0", 4'd0, 1'b1, 32'h100, 32'h200, 4'd1, 16'd5);
        read_chk("single_idx1", 4'd1, 1'b0, 32'h0, 32'h0, 4'd0, 16'd0);

        // Dual-port record after 2 idle cycles: port0 gets cc=2, port1 gets 0
        tick();
        tick();
        valid        = 2'b11;
        source_pc[0] = 32'h110; target_pc[0] = 32'h210; ttype[0] = 4'd2;
        source_pc[1] = 32'h120; target_pc[1] = 32'h220; ttype[1] = 4'd3;
        tick();
        idle();
        chk("dual_count", count, 5'd3);
        read_chk("dual_idx0", 4'd0, 1'b1, 32'h120, 32'h220, 4'd3, 16'd0);
        read_chk("dual_idx1", 4'd1, 1'b1, 32'h110, 32'h210, 4'd2, 16'd2);
        read_chk("dual_idx2", 4'd2, 1'b1, 32'h100, 32'h200, 4'd1, 16'd5);

        // Masked type: dropped, cc keeps counting (0 -> 1 -> 2)
        type_mask = 16'h0004;
        put0(32'h130, 32'h230, 4'd2);
        tick();
        idle();
        type_mask = 16'h0000;
        chk("mask_count", count, 5'd3);
        tick();
        put0(32'h140, 32'h240, 4'd5);
        tick();
        idle();
        chk("mask_after_count", count, 5'd4);
        read_chk("mask_after_idx0", 4'd0, 1'b1, 32'h140, 32'h240, 4'd5, 16'd2);

        // Freeze for 3 cycles with valid input: nothing recorded, cc holds at 1
        tick();
        freeze = 1'b1;
        put0(32'h150, 32'h250, 4'd1);
        repeat (3) tick();
        chk("freeze_count", count, 5'd4);
        freeze = 1'b0;
        put0(32'h160, 32'h260, 4'd9);
        tick();
        idle();
        chk("unfreeze_count", count, 5'd5);
        read_chk("unfreeze_idx0", 4'd0, 1'b1, 32'h160, 32'h260, 4'd9, 16'd1);

        // Clear, then 17 back-to-back single records
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr1_count", count, 5'd0);
        for (int k = 1; k <= 16; k++) begin
            put0(32'h1000 + 32'(k), 32'h2000 + 32'(k), 4'd1);
            tick();
        end
        chk("full16_count", count, 5'd16);
        chk("full16_ovf", overflow, 1'b0);
        put0(32'h1011, 32'h2011, 4'd1);
        tick();
        idle();
        chk("ovf_count", count, 5'd16);
        chk("ovf_flag", overflow, 1'b1);
        read_chk("ovf_idx0", 4'd0, 1'b1, 32'h1011, 32'h2011, 4'd1, 16'd0);
        read_chk("ovf_idx15", 4'd15, 1'b1, 32'h1002, 32'h2002, 4'd1, 16'd0);
        tick();
        chk("ovf_sticky", overflow, 1'b1);

        // Clear in the same cycle as a valid record: record dropped
        clear = 1'b1;
        put0(32'h300, 32'h400, 4'd1);
        tick();
        clear = 1'b0;
        idle();
        chk("clr2_count", count, 5'd0);
        chk("clr2_ovf", overflow, 1'b0);
        read_chk("clr2_idx0", 4'd0, 1'b0, 32'h0, 32'h0, 4'd0, 16'd0);

        // Post-clear write lands as the only record
        put0(32'h310, 32'h410, 4'd13);
        tick();
        idle();
        chk("postclr_count", count, 5'd1);
        read_chk("postclr_idx0", 4'd0, 1'b1, 32'h310, 32'h410, 4'd13, 16'd0);

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", count, 5'd0);
        read_chk("arst_idx0", 4'd0, 1'b0, 32'h0, 32'h0, 4'd0, 16'd0);
        tick();
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
